// File: rtl/trigger_pulse_gen_if.sv
// trigger_pulse_gen_if: trigger inputs, shared runtime configuration and per-channel status outputs
interface trigger_pulse_gen_if #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32
);
  logic [N_CH-1:0] switch;
  logic enable;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] holdoff;
  logic clear_missed;
  logic [N_CH-1:0] pulse;
  logic [N_CH-1:0] LED;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] missed;
  modport master (
    output switch, enable, pulse_width, holdoff, clear_missed,
    input pulse, LED, busy, missed
  );
  modport slave (
    input switch, enable, pulse_width, holdoff, clear_missed,
    output pulse, LED, busy, missed
  );
endinterface

// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen: per-channel sync, debounce, edge detect, runtime-width pulse with holdoff,
// LED toggle on each accepted trigger and sticky flag for triggers lost while busy.
module trigger_pulse_gen #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE = 0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic clock,
  input logic reset,
  trigger_pulse_gen_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_e;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic s1_q, s2_q, stable_q, stable_d, prev_q, ev_q, ev_d, miss;
    logic [DB_W-1:0] db_q, db_d;
    state_e st_q;
    logic [CNT_W-1:0] cnt_q, hold_q;
    logic pulse_q, led_q, busy_q, missed_q;
    always_comb begin
      stable_d = (s2_q != stable_q && db_q == DB_LAST) ? s2_q : stable_q;
      db_d = (s2_q == stable_q || db_q == DB_LAST) ? '0 : db_q + DB_W'(1);
      ev_d = (stable_q != prev_q) && (EDGE_MODE == 2 || stable_q == (EDGE_MODE == 1));
      miss = ev_q && st_q != IDLE;
    end
    // cnt_q counts the pulse down to 1, then is reloaded with the holdoff length
    always_ff @(posedge clock) begin
      if (reset) begin
        s1_q <= IDLE_LEVEL;
        s2_q <= IDLE_LEVEL;
        stable_q <= IDLE_LEVEL;
        prev_q <= IDLE_LEVEL;
        db_q <= '0;
        ev_q <= 1'b0;
        st_q <= IDLE;
        cnt_q <= '0;
        hold_q <= '0;
        pulse_q <= 1'b0;
        led_q <= 1'b0;
        busy_q <= 1'b0;
        missed_q <= 1'b0;
      end else begin
        s1_q <= bus.switch[c];
        s2_q <= s1_q;
        stable_q <= stable_d;
        db_q <= db_d;
        prev_q <= stable_q;
        ev_q <= ev_d;
        missed_q <= miss | (missed_q & ~bus.clear_missed);
        case (st_q)
          IDLE: if (ev_q && bus.enable) begin
            st_q <= PULSE;
            pulse_q <= 1'b1;
            busy_q <= 1'b1;
            led_q <= ~led_q;
            cnt_q <= (bus.pulse_width == '0) ? CNT_W'(1) : bus.pulse_width;
            hold_q <= bus.holdoff;
          end
          PULSE: if (cnt_q == CNT_W'(1)) begin
            st_q <= (hold_q == '0) ? IDLE : HOLDOFF;
            pulse_q <= 1'b0;
            busy_q <= hold_q != '0;
            cnt_q <= hold_q;
          end else cnt_q <= cnt_q - CNT_W'(1);
          HOLDOFF: if (cnt_q == CNT_W'(1)) begin
            st_q <= IDLE;
            busy_q <= 1'b0;
          end else cnt_q <= cnt_q - CNT_W'(1);
          default: st_q <= IDLE;
        endcase
      end
    end
    assign bus.pulse[c] = pulse_q;
    assign bus.LED[c] = led_q;
    assign bus.busy[c] = busy_q;
    assign bus.missed[c] = missed_q;
  end
endmodule

// File: tb/tb_trigger_pulse_gen.sv
// tb_trigger_pulse_gen: falling-edge and both-edge instances driven identically, checked each cycle
// against a timestamp model (pulse/busy windows, sample history) plus directed literal checks.
module tb_trigger_pulse_gen;
  localparam int N = 4;
  localparam int CW = 8;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] sw = '1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [CW-1:0] pw = '0;
  logic [CW-1:0] ho = '0;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  bit chk = 1'b0;
  trigger_pulse_gen_if #(.N_CH(N), .CNT_W(CW)) bus0 ();
  trigger_pulse_gen_if #(.N_CH(N), .CNT_W(CW)) bus2 ();
  assign bus0.switch = sw;
  assign bus0.enable = en;
  assign bus0.pulse_width = pw;
  assign bus0.holdoff = ho;
  assign bus0.clear_missed = clr;
  assign bus2.switch = sw;
  assign bus2.enable = en;
  assign bus2.pulse_width = pw;
  assign bus2.holdoff = ho;
  assign bus2.clear_missed = clr;
  trigger_pulse_gen #(.N_CH(N), .CNT_W(CW), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .IDLE_LEVEL(1'b1))
    u0 (.clock(clock), .reset(reset), .bus(bus0));
  trigger_pulse_gen #(.N_CH(N), .CNT_W(CW), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .IDLE_LEVEL(1'b1))
    u2 (.clock(clock), .reset(reset), .bus(bus2));
  initial forever #5 clock = ~clock;
  logic s1m[N], s2m[N], stm[N];
  logic [D-1:0] hm[N];
  int lcm[N];
  int evm[2][N], stt[2][N], pe[2][N], be[2][N];
  logic ledm[2][N], mism[2][N];
  // Model: a level change is accepted once the last D synchronised samples, all taken since the
  // previous change, disagree with the current level; an accepted edge reaches the pulse logic two
  // edges later and is dropped (and flagged) if the channel was busy in the cycle it arrived.
  task automatic model_step();
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        s1m[c] = 1'b1;
        s2m[c] = 1'b1;
        stm[c] = 1'b1;
        hm[c] = '1;
        lcm[c] = cyc;
        for (int m = 0; m < 2; m++) begin
          evm[m][c] = -1;
          stt[m][c] = 0;
          pe[m][c] = -1;
          be[m][c] = -1;
          ledm[m][c] = 1'b0;
          mism[m][c] = 1'b0;
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          logic miss;
          int w;
          miss = 1'b0;
          if (evm[m][c] == cyc) begin
            if (be[m][c] >= cyc - 1) miss = 1'b1;
            else if (en) begin
              w = (pw == 0) ? 1 : int'(pw);
              stt[m][c] = cyc;
              pe[m][c] = cyc + w - 1;
              be[m][c] = cyc + w + int'(ho) - 1;
              ledm[m][c] = ~ledm[m][c];
            end
          end
          mism[m][c] = miss ? 1'b1 : clr ? 1'b0 : mism[m][c];
        end
        hm[c] = {hm[c][D-2:0], s2m[c]};
        if (cyc - lcm[c] >= D && hm[c] == {D{~stm[c]}}) begin
          stm[c] = ~stm[c];
          lcm[c] = cyc;
          evm[0][c] = stm[c] ? -1 : cyc + 2;
          evm[1][c] = cyc + 2;
        end
        s2m[c] = s1m[c];
        s1m[c] = sw[c];
      end
    end
  endtask
  initial forever begin
    @(posedge clock);
    model_step();
  end
  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask
  task automatic check_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clock);
    if (chk) begin
      for (int m = 0; m < 2; m++) begin
        logic [N-1:0] ep, eb, el, em;
        for (int c = 0; c < N; c++) begin
          ep[c] = stt[m][c] <= cyc && cyc <= pe[m][c];
          eb[c] = stt[m][c] <= cyc && cyc <= be[m][c];
          el[c] = ledm[m][c];
          em[c] = mism[m][c];
        end
        check(m == 0 ? "pulse_fall" : "pulse_both", m == 0 ? bus0.pulse : bus2.pulse, ep);
        check(m == 0 ? "busy_fall" : "busy_both", m == 0 ? bus0.busy : bus2.busy, eb);
        check(m == 0 ? "led_fall" : "led_both", m == 0 ? bus0.LED : bus2.LED, el);
        check(m == 0 ? "missed_fall" : "missed_both", m == 0 ? bus0.missed : bus2.missed, em);
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic run0(int n, int ch, output int hi, output int first);
    hi = 0;
    first = -1;
    repeat (n) begin
      tick(1);
      if (bus0.pulse[ch]) begin
        hi++;
        if (first < 0) first = cyc;
      end
    end
  endtask
  initial begin
    int k, hi, first, h1, h2, tg;
    logic last;
    tick(3);
    reset = 1'b0;
    chk = 1'b1;
    check("rst_pulse", bus0.pulse, '0);
    check("rst_busy", bus0.busy, '0);
    check("rst_led", bus0.LED, '0);
    check("rst_missed", bus0.missed, '0);
    en = 1'b1;
    pw = 8'd5;
    ho = 8'd0;
    tick(10);
    k = cyc + 1;
    sw[0] = 1'b0;
    run0(16, 0, hi, first);
    check_int("fall_first", first, k + 7);
    check_int("fall_len", hi, 5);
    check("fall_led", bus0.LED, 4'b0001);
    check("fall_missed", bus0.missed, '0);
    sw[0] = 1'b1;
    tick(12);
    sw[0] = 1'b0;
    run0(3, 0, h1, first);
    sw[0] = 1'b1;
    run0(16, 0, h2, first);
    check_int("glitch_pulses", h1 + h2, 0);
    check("glitch_led", bus0.LED, 4'b0001);
    check_int("glitch_dbcnt", int'(u0.g_ch[0].db_q), 0);
    pw = 8'd3;
    ho = 8'd10;
    sw[0] = 1'b0;
    run0(5, 0, h1, first);
    sw[0] = 1'b1;
    run0(5, 0, h2, first);
    sw[0] = 1'b0;
    run0(20, 0, hi, first);
    check_int("busy_one_pulse", h1 + h2 + hi, 3);
    check("busy_missed", bus0.missed, 4'b0001);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clear_missed", bus0.missed, '0);
    sw[0] = 1'b1;
    run0(10, 0, h1, first);
    sw[0] = 1'b0;
    run0(25, 0, hi, first);
    check_int("after_busy_pulse", h1 + hi, 3);
    pw = 8'd0;
    ho = 8'd0;
    hi = 0;
    tg = 0;
    last = bus2.LED[1];
    for (int i = 0; i < 25; i++) begin
      if (i == 0) sw[1] = 1'b0;
      if (i == 8) sw[1] = 1'b1;
      tick(1);
      if (bus2.pulse[1]) hi++;
      if (bus2.LED[1] != last) tg++;
      last = bus2.LED[1];
    end
    check_int("both_pulses", hi, 2);
    check_int("both_toggles", tg, 2);
    check("both_led", {3'b000, bus2.LED[1]}, 4'b0000);
    pw = 8'd5;
    ho = 8'd3;
    sw[0] = 1'b1;
    tick(12);
    k = cyc + 1;
    sw[0] = 1'b0;
    tick(8);
    check("midpulse_high", {3'b000, bus0.pulse[0]}, 4'b0001);
    reset = 1'b1;
    tick(1);
    check("abort_pulse", bus0.pulse, '0);
    check("abort_busy", bus0.busy, '0);
    check("abort_led", bus0.LED, '0);
    check("abort_missed", bus0.missed, '0);
    reset = 1'b0;
    sw = '1;
    hi = 0;
    repeat (20) begin
      tick(1);
      if (bus0.pulse != '0 || bus2.pulse != '0) hi++;
    end
    check_int("post_reset_quiet", hi, 0);
    en = 1'b0;
    sw = '0;
    hi = 0;
    repeat (20) begin
      tick(1);
      if (bus0.pulse != '0) hi++;
    end
    check_int("disabled_pulses", hi, 0);
    check("disabled_missed", bus0.missed, '0);
    sw = '1;
    tick(12);
    en = 1'b1;
    k = cyc + 1;
    sw = '0;
    tick(7);
    check("all_before", bus0.pulse, '0);
    tick(1);
    check("all_together", bus0.pulse, 4'b1111);
    tick(20);
    sw[0] = 1'b1;
    tick(12);
    pw = 8'hFF;
    ho = 8'd0;
    sw[0] = 1'b0;
    run0(275, 0, hi, first);
    check_int("max_width", hi, 255);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 11) == 0) sw[c] = ~sw[c];
      en = $urandom_range(0, 7) != 0;
      clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 39) == 0) begin
        pw = CW'($urandom_range(0, 6));
        ho = CW'($urandom_range(0, 9));
      end
      reset = $urandom_range(0, 599) == 0;
      tick(1);
    end
    reset = 1'b0;
    clr = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/trigger_pulse_gen.md
Name: trigger_pulse_gen

Overview:
- Multi-channel successor to the single-switch falling-edge pulser used in the PMT timebin design.
- Each channel does three things in order:
  - synchronises and debounces an asynchronous switch/trigger input;
  - detects a configurable edge;
  - emits a pulse whose width is set at runtime, then applies a holdoff.
- Per channel it also toggles an indicator LED on each accepted trigger and flags triggers lost while busy.
- It sits between front-panel or external trigger inputs and the timebin counting logic.

Parameters:
- N_CH, 4, number of independent trigger channels (>=1).
- CNT_W, 32, width of the pulse_width and holdoff counters.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>=1).
- EDGE_MODE, 0, edge that fires: 0 = falling, 1 = rising, 2 = both.
- IDLE_LEVEL, 1, reset value of the synchroniser and debounced level (input idles high).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- switch  input  N_CH  asynchronous trigger inputs, one bit per channel.
- enable  input  1  global trigger enable.
- pulse_width  input  CNT_W  pulse high time in clock cycles, shared by all channels.
- holdoff  input  CNT_W  dead time after the pulse in clock cycles, shared.
- clear_missed  input  1  one-cycle strobe that clears all missed flags.
- pulse  output  N_CH  registered output pulses.
- LED  output  N_CH  registered toggle indicator per channel.
- busy  output  N_CH  high while the channel is in PULSE or HOLDOFF.
- missed  output  N_CH  sticky flag: an edge was detected while busy.

Behaviour:
- Reset (clock edge with reset=1):
  - pulse, LED, busy and missed go to 0.
  - Synchroniser flops and the debounced level go to IDLE_LEVEL.
  - Debounce counter goes to 0 and the FSM goes to IDLE.
  - Reset mid-pulse aborts the pulse on that edge.
  - No edge is reported on the first cycles after reset when switch==IDLE_LEVEL.
- Synchroniser: two-flop chain per channel (s1, s2).
- Debounce, per channel, comparing s2 against the debounced level stable:
  - If s2==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES samples resets cnt and is never seen.
- Edge strobe:
  - ev is a one-cycle registered strobe, set on the cycle after stable changes.
  - It fires only when the direction matches EDGE_MODE.
  - EDGE_MODE=2 fires on both directions.
- Latency: switch sampled changed at edge k, held steady, gives ev high in cycle k+DEBOUNCE_CYCLES+2 and pulse high in cycle k+DEBOUNCE_CYCLES+3.
- FSM per channel, states IDLE, PULSE, HOLDOFF:
  - IDLE:
    - ev && enable: go to PULSE, pulse<=1, busy<=1, LED<=~LED.
    - Latch width_q = (pulse_width==0 ? 1 : pulse_width) and hold_q = holdoff at this edge. Later changes to the inputs do not affect a running pulse.
    - ev with enable=0: ignored, missed not set.
  - PULSE:
    - pulse stays high for exactly width_q cycles, counted by a down-counter.
    - On the last cycle: if hold_q==0, go to IDLE with pulse<=0 and busy<=0; else go to HOLDOFF with pulse<=0 and busy staying 1.
  - HOLDOFF:
    - busy stays high for hold_q cycles, then go to IDLE with busy<=0.
    - The channel can accept a new ev in the first IDLE cycle.
- Overlapping triggers:
  - ev in PULSE or HOLDOFF, with any enable, sets missed[ch]<=1 and is otherwise dropped. No retrigger and no queueing.
  - missed is sticky until reset or clear_missed.
  - If clear_missed and a new miss occur in the same cycle, the miss wins and missed stays 1.
- enable deasserted mid-operation: the pulse and holdoff in progress complete normally.
- Channels are fully independent. Simultaneous events on different channels are all serviced in the same cycle.
- Counter width: counters are CNT_W bits.
  - pulse_width = 2^CNT_W-1 is legal.
  - No wrap occurs, because counters count down from the latched value to 1.

Test Plan:
- DEBOUNCE_CYCLES=4, EDGE_MODE=0, pulse_width=5, holdoff=0, enable=1. Drive switch[0] 1->0 at edge 10 and hold. Required: pulse[0] high cycles 17-21; LED[0] 0->1 at 17; busy[0] high 17-21; missed=0.
- Same configuration, switch[0] low for only 3 cycles, then high. Required: no pulse, LED unchanged, debounce counter back at 0.
- pulse_width=3, holdoff=10. Second valid falling edge arrives while busy. Required: one pulse of 3 cycles, missed[0]=1. A clear_missed strobe then returns missed[0] to 0. An edge after busy falls produces a new pulse.
- EDGE_MODE=2, pulse_width=0. Drive a clean low then high on switch[1]. Required: two 1-cycle pulses, LED[1] toggles twice back to 0.
- Assert reset during the 2nd cycle of a 5-cycle pulse. Required: pulse, busy, LED and missed all 0 on the next edge. With switch idle high, no pulse follows reset.
- Drive valid falling edges on all 4 channels in the same cycle with enable=0, then with enable=1. Required: first case no pulses and missed=0; second case all four pulse in the same cycle.
